serial_add_seq: RTL and testbench
=================================

Name: serial_add_seq

Overview:
- Bit-serial add/subtract sequencer: computes one WIDTH-bit add or subtract using exactly one 1-bit full-adder evaluation per clock, LSB first.
- Owns the operand/result shift registers, the carry flop, the bit counter and the start/busy/done handshake.
- Sits in the matrix-multiplication datapath as the area-minimal accumulate step.
- The upstream controller issues one operation at a time and waits for done.

Parameters:
- WIDTH, 8, operand/result width in bits; legal range WIDTH >= 2.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- rst  input  1  synchronous, active-high reset.
- start  input  1  request a new operation; sampled only in IDLE.
- sub  input  1  0 = a+b, 1 = a-b; captured with start.
- a  input  WIDTH  operand A; captured with start.
- b  input  WIDTH  operand B; captured with start.
- busy  output  1  high while an operation is in progress (RUN or DONE).
- done  output  1  one-cycle pulse; sum, c_out and overflow are valid from this cycle on.
- sum  output  WIDTH  result (a+b or a-b, modulo 2^WIDTH).
- c_out  output  1  carry out of the MSB; for subtract, 1 = no borrow (a >= b unsigned).
- overflow  output  1  two's-complement overflow = (carry into MSB) XOR (carry out of MSB).

Behaviour:
- One clock domain. rst is synchronous, active-high, and overrides all other inputs.
- Reset values: state=IDLE; busy=0, done=0, sum=0, c_out=0, overflow=0; internal shift regs, carry and counter all 0.
- FSM states:
  - IDLE: busy=0.
    - start=1 -> capture a into the A shift reg and (sub ? ~b : b) into the B shift reg.
    - Set carry=sub, cnt=0, go to RUN.
    - sum, c_out and overflow keep their last values until RUN begins updating them.
  - RUN: busy=1. Each cycle:
    - s = A[0]^B[0]^carry.
    - carry <= majority(A[0], B[0], carry).
    - Shift A and B right by 1.
    - Shift s into the result MSB; result shifts right.
    - cnt <= cnt+1.
    - On the cycle cnt==WIDTH-2, also latch the carry-in of the MSB for overflow.
    - When cnt==WIDTH-1 (last bit), go to DONE.
  - DONE: busy=1, done=1 for exactly this cycle.
    - sum = full result; c_out = final carry; overflow computed.
    - Unconditionally return to IDLE next cycle.
- Latency: start sampled in cycle 0; RUN occupies cycles 1..WIDTH; done=1 in cycle WIDTH+1; a new start is accepted from cycle WIDTH+2.
- Throughput: one operation per WIDTH+2 cycles.
- sum may show partial values during RUN; it is valid only from done onward.
- After DONE, sum/c_out/overflow hold until the next accepted start.
- start while busy=1 (RUN or DONE) is ignored: no capture, no queueing, no effect on the operation in flight.
- a, b and sub may change freely after the capture cycle without affecting the result.
- rst during RUN or DONE aborts the operation:
  - Next cycle: IDLE with all outputs at reset values.
  - No done pulse is produced for the aborted operation.
- rst and start asserted together: rst wins, start is discarded.
- Counter width is $clog2(WIDTH). cnt never exceeds WIDTH-1 and never wraps during an operation.
- Arithmetic is modulo 2^WIDTH. Subtract is a + ~b + 1, using the carry-in seeded by sub.
- No combinational path from inputs to outputs; all outputs are registered.

Test Plan:
- WIDTH=8, sub=0, a=0x3C, b=0x19, start pulse in cycle 0 -> busy high cycles 1–9, done=1 only in cycle 9, sum=0x55, c_out=0, overflow=0.
- sub=0, a=0xFF, b=0x01 -> sum=0x00, c_out=1, overflow=0. Then a=0x7F, b=0x01 -> sum=0x80, c_out=0, overflow=1.
- sub=1, a=0x05, b=0x07 -> sum=0xFE, c_out=0, overflow=0. Then sub=1, a=0x80, b=0x01 -> sum=0x7F, c_out=1, overflow=1.
- Back-to-back: start held high continuously with a=0x10, b=0x20 -> operations accepted only in cycles 0, 10, 20…; each done pulse is one cycle wide and shows sum=0x30. Changing a/b mid-RUN does not alter that operation's sum.
- rst asserted in cycle 4 of an operation -> cycle 5 shows busy=0, done=0, sum=0; no done pulse follows. A new start in cycle 5 completes normally with done in cycle 14.
- rst and start high in the same cycle -> no operation starts; busy stays 0.

Source files
------------

// File: rtl/serial_add_seq.sv
// serial_add_seq: bit-serial add/subtract, one full-adder evaluation per clock, LSB first.
module serial_add_seq #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             sub,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             c_out,
    output logic             overflow
);
    localparam int CW = $clog2(WIDTH);
    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
    state_t           state, state_nxt;
    logic [WIDTH-1:0] a_sr, b_sr;
    logic [CW-1:0]    cnt;
    logic             carry, c_msb, s, c_nxt, last;
    assign s     = a_sr[0] ^ b_sr[0] ^ carry;
    assign c_nxt = (a_sr[0] & b_sr[0]) | (a_sr[0] & carry) | (b_sr[0] & carry);
    assign last  = cnt == CW'(WIDTH - 1);
    assign busy  = state != IDLE;
    assign done  = state == DONE;
    always_comb begin
        state_nxt = state == IDLE ? (start ? RUN : IDLE)
                  : state == RUN  ? (last ? DONE : RUN)
                  : IDLE;
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            a_sr     <= '0;
            b_sr     <= '0;
            sum      <= '0;
            cnt      <= '0;
            carry    <= 1'b0;
            c_msb    <= 1'b0;
            c_out    <= 1'b0;
            overflow <= 1'b0;
        end else begin
            state <= state_nxt;
            if (state == IDLE && start) begin
                a_sr  <= a;
                b_sr  <= sub ? ~b : b;
                carry <= sub;
                cnt   <= '0;
            end else if (state == RUN) begin
                a_sr  <= a_sr >> 1;
                b_sr  <= b_sr >> 1;
                sum   <= {s, sum[WIDTH-1:1]};
                carry <= c_nxt;
                cnt   <= last ? cnt : cnt + CW'(1);
                // carry into the MSB, needed later for the overflow flag
                if (cnt == CW'(WIDTH - 2)) c_msb <= c_nxt;
                if (last) begin
                    c_out    <= c_nxt;
                    overflow <= c_msb ^ c_nxt;
                end
            end
        end
    end
endmodule

// File: tb/tb_serial_add_seq.sv
// tb_serial_add_seq: directed scoreboard bench for serial_add_seq (WIDTH=8).
module tb_serial_add_seq;
    logic       clk = 1'b0, rst = 1'b1, start = 1'b0, sub = 1'b0;
    logic [7:0] a = '0, b = '0;
    logic       busy, done, c_out, overflow;
    logic [7:0] sum;
    logic [9:0] q[$];
    int         n_chk = 0, n_fail = 0;

    serial_add_seq #(.WIDTH(8)) dut (
        .clk(clk), .rst(rst), .start(start), .sub(sub), .a(a), .b(b),
        .busy(busy), .done(done), .sum(sum), .c_out(c_out), .overflow(overflow)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // expected {overflow, c_out, sum} from plain integer arithmetic
    function automatic logic [9:0] model(input logic s_i, input logic [7:0] a_i, input logic [7:0] b_i);
        logic [7:0] bb;
        logic [8:0] r;
        bb = s_i ? ~b_i : b_i;
        r  = {1'b0, a_i} + {1'b0, bb} + {8'd0, s_i};
        return {(a_i[7] == bb[7]) && (r[7] != a_i[7]), r[8], r[7:0]};
    endfunction

    task automatic start_op(input logic s_i, input logic [7:0] a_i, input logic [7:0] b_i);
        start = 1'b1; sub = s_i; a = a_i; b = b_i;
        q.push_back(model(s_i, a_i, b_i));
    endtask

    task automatic check_done();
        logic [9:0] e;
        if (q.size() == 0) chk("sb_empty", 1, 0);
        else begin
            e = q.pop_front();
            chk("sum", sum, e[7:0]);
            chk("c_out", c_out, e[8]);
            chk("overflow", overflow, e[9]);
        end
    endtask

    // called at the negedge of cycle 0 after start_op; ends at cycle 10
    task automatic wait_done();
        for (int c = 1; c <= 10; c++) begin
            @(negedge clk);
            start = 1'b0;
            if (c == 2) begin a = 8'($urandom); b = 8'($urandom); sub = ~sub; end
            chk("busy", busy, c <= 9);
            chk("done", done, c == 9);
            if (done) check_done();
        end
    endtask

    initial begin
        @(negedge clk);
        @(negedge clk);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_sum", sum, 0);
        chk("rst_cout", c_out, 0);
        chk("rst_ovf", overflow, 0);
        rst = 1'b0;
        @(negedge clk);
        start_op(0, 8'h3C, 8'h19); wait_done();
        chk("held_sum", sum, 8'h55);
        start_op(0, 8'hFF, 8'h01); wait_done();
        start_op(0, 8'h7F, 8'h01); wait_done();
        start_op(1, 8'h05, 8'h07); wait_done();
        start_op(1, 8'h80, 8'h01); wait_done();
        start_op(1, 8'h3C, 8'h3C); wait_done();
        // start held high: accepted every 10 cycles
        start_op(0, 8'h10, 8'h20);
        for (int k = 0; k < 3; k++) begin
            for (int c = 1; c <= 10; c++) begin
                @(negedge clk);
                if (c == 3) begin a = 8'($urandom); b = 8'($urandom); end
                if (c == 8) begin a = 8'h10; b = 8'h20; end
                chk("b2b_busy", busy, c <= 9);
                chk("b2b_done", done, c == 9);
                if (done) check_done();
                if (c == 10) begin
                    if (k < 2) q.push_back(model(0, 8'h10, 8'h20));
                    else start = 1'b0;
                end
            end
        end
        @(negedge clk);
        chk("b2b_idle", busy, 0);
        // abort in cycle 4
        start_op(0, 8'h12, 8'h34);
        for (int c = 1; c <= 4; c++) begin
            @(negedge clk);
            start = 1'b0;
            chk("pre_abort_busy", busy, 1);
            if (c == 4) rst = 1'b1;
        end
        @(negedge clk);
        void'(q.pop_back());
        rst = 1'b0;
        chk("abort_busy", busy, 0);
        chk("abort_done", done, 0);
        chk("abort_sum", sum, 0);
        chk("abort_cout", c_out, 0);
        start_op(1, 8'h01, 8'h02); wait_done();
        // rst and start together
        rst = 1'b1; start_op(0, 8'h11, 8'h22);
        void'(q.pop_back());
        @(negedge clk);
        rst = 1'b0; start = 1'b0;
        chk("rs_busy", busy, 0);
        @(negedge clk);
        chk("rs_busy2", busy, 0);
        chk("rs_done", done, 0);
        chk("sb_drained", q.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
